// File: rtl/irq_watchdog_timer.sv
// Periodic 6502 IRQ generator with watchdog and CPU reset pulse generation.
// Acks and kicks are edge-detected write strobes from the address decoder.
module irq_watchdog_timer #(
  parameter int IRQ_PERIOD = 6250,
  parameter int WD_LIMIT   = 16,
  parameter int RST_LEN    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_en,
  input  logic irqres_n,
  input  logic watchdog_n,
  output logic irq_n,
  output logic cpu_reset,
  output logic frame_tick,
  output logic wd_fired
);

  localparam int PW = (IRQ_PERIOD > 1) ? $clog2(IRQ_PERIOD) : 1;
  localparam int WW = (WD_LIMIT > 1) ? $clog2(WD_LIMIT) : 1;
  localparam int RW = (RST_LEN > 1) ? $clog2(RST_LEN) : 1;

  localparam logic [PW-1:0] PER_LAST = PW'(IRQ_PERIOD - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(WD_LIMIT - 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_LEN - 1);

  typedef enum logic {
    RESET_OUT = 1'b0,
    RUN       = 1'b1
  } state_t;

  state_t        state;
  logic [RW-1:0] rst_cnt;
  logic [PW-1:0] per_cnt;
  logic [WW-1:0] wd_cnt;
  logic          irqres_q;
  logic          watchdog_q;

  logic ack;
  logic kick;
  logic wrap;

  // One event per falling edge of each strobe, however long it is held low.
  assign ack  = !irqres_n && irqres_q;
  assign kick = !watchdog_n && watchdog_q;
  assign wrap = tick_en && (per_cnt == PER_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RESET_OUT;
      rst_cnt    <= '0;
      per_cnt    <= '0;
      wd_cnt     <= '0;
      irq_n      <= 1'b1;
      cpu_reset  <= 1'b1;
      frame_tick <= 1'b0;
      wd_fired   <= 1'b0;
      irqres_q   <= 1'b1;
      watchdog_q <= 1'b1;
    end else begin
      irqres_q   <= irqres_n;
      watchdog_q <= watchdog_n;
      frame_tick <= 1'b0;
      case (state)
        RESET_OUT: begin
          per_cnt <= '0;
          wd_cnt  <= '0;
          irq_n   <= 1'b1;
          if (rst_cnt == RST_LAST) begin
            state     <= RUN;
            cpu_reset <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        RUN: begin
          // A kick arriving on the fatal wrap still rescues the CPU.
          if (wrap && !kick && (wd_cnt == WD_LAST)) begin
            state     <= RESET_OUT;
            wd_fired  <= 1'b1;
            cpu_reset <= 1'b1;
            irq_n     <= 1'b1;
            per_cnt   <= '0;
            wd_cnt    <= '0;
            rst_cnt   <= '0;
          end else begin
            if (tick_en) begin
              per_cnt <= wrap ? '0 : per_cnt + 1'b1;
            end
            // New request beats a simultaneous ack so no interrupt is lost.
            if (wrap) begin
              irq_n      <= 1'b0;
              frame_tick <= 1'b1;
            end else if (ack) begin
              irq_n <= 1'b1;
            end
            if (kick) begin
              wd_cnt <= '0;
            end else if (wrap) begin
              wd_cnt <= wd_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_watchdog_timer.sv
// Scoreboard bench for irq_watchdog_timer: a behavioural model queues expected
// outputs per cycle; a negedge monitor pops and compares them against the DUT.
module tb_irq_watchdog_timer;

  localparam int IRQ_PERIOD = 8;
  localparam int WD_LIMIT   = 3;
  localparam int RST_LEN    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick_en = 1'b1;
  logic irqres_n = 1'b1;
  logic watchdog_n = 1'b1;
  logic irq_n;
  logic cpu_reset;
  logic frame_tick;
  logic wd_fired;

  irq_watchdog_timer #(
    .IRQ_PERIOD(IRQ_PERIOD),
    .WD_LIMIT  (WD_LIMIT),
    .RST_LEN   (RST_LEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_en   (tick_en),
    .irqres_n  (irqres_n),
    .watchdog_n(watchdog_n),
    .irq_n     (irq_n),
    .cpu_reset (cpu_reset),
    .frame_tick(frame_tick),
    .wd_fired  (wd_fired)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  logic [3:0] exp_q[$];

  // model state: pulse countdown style rather than a state register
  int m_pulse_left;
  int m_phase;
  int m_misses;
  bit m_irq_n, m_cpu_reset, m_frame_tick, m_wd_fired;
  bit m_irqres_prev, m_wd_prev;

  // DUT-observed statistics over windows chosen by the stimulus process
  int ft_count = 0;
  int cr_count = 0;
  int cyc = 0;
  int last_ft = -1;
  int ft_gap = 0;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, want %0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic modelStep(input bit r, input bit t, input bit ir, input bit wd);
    bit ack_e, kick_e, wrap_e;
    if (r) begin
      m_pulse_left = RST_LEN;
      m_phase = 0;
      m_misses = 0;
      m_irq_n = 1;
      m_cpu_reset = 1;
      m_frame_tick = 0;
      m_wd_fired = 0;
      m_irqres_prev = 1;
      m_wd_prev = 1;
    end else begin
      ack_e  = (ir == 0) && m_irqres_prev;
      kick_e = (wd == 0) && m_wd_prev;
      m_frame_tick = 0;
      if (m_pulse_left > 0) begin
        m_pulse_left--;
        m_cpu_reset = (m_pulse_left > 0);
        m_irq_n = 1;
      end else begin
        wrap_e = t && (m_phase == IRQ_PERIOD - 1);
        if (t) m_phase = (m_phase + 1) % IRQ_PERIOD;
        if (kick_e) m_misses = 0;
        else if (wrap_e) m_misses++;
        if (m_misses >= WD_LIMIT) begin
          m_misses = 0;
          m_phase = 0;
          m_pulse_left = RST_LEN;
          m_cpu_reset = 1;
          m_wd_fired = 1;
          m_irq_n = 1;
        end else begin
          if (wrap_e) begin
            m_irq_n = 0;
            m_frame_tick = 1;
          end else if (ack_e) begin
            m_irq_n = 1;
          end
        end
      end
      m_irqres_prev = ir;
      m_wd_prev = wd;
    end
  endtask

  // Drive one clock worth of inputs, queue the expectation, return once compared.
  task automatic applyStimulus(input bit r, input bit t, input bit ir, input bit wd);
    rst = r;
    tick_en = t;
    irqres_n = ir;
    watchdog_n = wd;
    modelStep(r, t, ir, wd);
    exp_q.push_back({m_irq_n, m_cpu_reset, m_frame_tick, m_wd_fired});
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 1, 1, 1);
  endtask

  always @(negedge clk) begin
    logic [3:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cyc++;
      checkOutput("irq_n", int'(irq_n), int'(e[3]));
      checkOutput("cpu_reset", int'(cpu_reset), int'(e[2]));
      checkOutput("frame_tick", int'(frame_tick), int'(e[1]));
      checkOutput("wd_fired", int'(wd_fired), int'(e[0]));
      if (frame_tick === 1'b1) begin
        ft_count++;
        if (last_ft >= 0) ft_gap = cyc - last_ft;
        last_ft = cyc;
      end
      if (cpu_reset === 1'b1) cr_count++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got 1, want 0");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    bit fired;
    @(negedge clk);
    #1;

    // 1. power-on pulse
    applyStimulus(1, 1, 1, 1);
    cr_count = 0;
    ft_count = 0;
    applyStimulus(1, 1, 1, 1);
    idle(11);
    checkOutput("poweron_pulse_len", cr_count, RST_LEN);
    checkOutput("poweron_no_tick", ft_count, 0);
    checkOutput("poweron_wd_fired", int'(wd_fired), 0);

    // 2. first IRQ, then a 3-clk ack held low
    idle(1);
    checkOutput("first_irq", int'(irq_n), 0);
    checkOutput("first_tick", int'(frame_tick), 1);
    applyStimulus(0, 1, 0, 1);
    checkOutput("ack_release", int'(irq_n), 1);
    applyStimulus(0, 1, 0, 1);
    applyStimulus(0, 1, 0, 1);
    for (int i = 0; i < 16; i++) applyStimulus(0, 1, 1, (i % 8 == 0) ? 1'b0 : 1'b1);
    checkOutput("irq_held_no_ack", int'(irq_n), 0);

    // 3. one kick per period, coinciding with the wrap
    ft_count = 0;
    cr_count = 0;
    for (int i = 0; i < 20 * IRQ_PERIOD; i++)
      applyStimulus(0, 1, 1, (i % IRQ_PERIOD == 4) ? 1'b0 : 1'b1);
    checkOutput("kicked_ticks", ft_count, 20);
    checkOutput("kicked_no_reset", cr_count, 0);
    checkOutput("kicked_wd_fired", int'(wd_fired), 0);

    // 4. starve the watchdog
    ft_count = 0;
    cr_count = 0;
    idle(40);
    checkOutput("fire_pulse_len", cr_count, RST_LEN);
    checkOutput("fire_ticks", ft_count, 3);
    checkOutput("fire_sticky", int'(wd_fired), 1);

    // 5. ack on a wrap edge, then a kick on the fatal wrap
    applyStimulus(0, 1, 0, 1);
    checkOutput("ack_vs_wrap", int'(irq_n), 0);
    idle(7);
    applyStimulus(0, 1, 1, 0);
    cr_count = 0;
    idle(23);
    checkOutput("kick_saves", cr_count, 0);
    idle(1);
    checkOutput("fire_after_3_more", int'(cpu_reset), 1);
    idle(4);

    // 6a. tick_en every other clk
    ft_count = 0;
    cr_count = 0;
    last_ft = -1;
    ft_gap = 0;
    for (int i = 0; i < 64; i++)
      applyStimulus(0, (i % 2 == 0) ? 1'b1 : 1'b0, 1, (i % 16 == 0) ? 1'b0 : 1'b1);
    checkOutput("gated_ticks", ft_count, 4);
    checkOutput("gated_gap", ft_gap, 16);
    checkOutput("gated_no_reset", cr_count, 0);

    // 6b. rst while a watchdog reset pulse is in progress
    fired = 0;
    for (int i = 0; i < 100 && !fired; i++) begin
      idle(1);
      if (cpu_reset === 1'b1) fired = 1;
    end
    checkOutput("wd_fire_wait", int'(fired), 1);
    idle(1);
    cr_count = 0;
    applyStimulus(1, 1, 1, 1);
    checkOutput("midop_wd_clear", int'(wd_fired), 0);
    idle(11);
    checkOutput("midop_pulse_len", cr_count, RST_LEN);
    checkOutput("midop_wd_fired", int'(wd_fired), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
